i2c_write_scheduler: RTL
========================

Name: i2c_write_scheduler

Overview:
- Arbitrates between NUM_REQ requesters that each want to write one data byte to a 7-bit I2C target, for example a PCF8574 port expander.
- Sequences the byte-level I2C master through START+address, data and STOP.
- Retries on NACK and enforces a per-phase timeout.
- Sits between application logic (LED/LCD drivers) and the single shared I2C master.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_RETRY, 3, attempts after the first NACK before an error is reported.
- TIMEOUT_CYCLES, 2000000, maximum cycles allowed in any wait state before abort.
- BACKOFF_CYCLES, 1000, idle cycles between a NACK-terminated attempt and its retry.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request level, held until done or err
- req_addr  in  7*NUM_REQ  per-requester 7-bit target address
- req_data  in  8*NUM_REQ  per-requester data byte
- gnt  out  NUM_REQ  one-hot, high for the whole transaction of the granted requester
- done  out  NUM_REQ  one-cycle pulse: transaction ACKed and STOP sent
- err  out  NUM_REQ  one-cycle pulse: retries exhausted or timeout
- m_start  out  1  pulse: master sends START then m_byte
- m_write  out  1  pulse: master sends m_byte
- m_stop  out  1  pulse: master sends STOP
- m_byte  out  8  byte for the master, held stable while the command is outstanding
- m_busy  in  1  master busy
- m_nack  in  1  ACK bit of the last byte, valid on the cycle m_busy falls
- active  out  1  high when the state machine is not in IDLE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; gnt, done, err, m_start, m_write, m_stop = 0; m_byte=0.
  - Round-robin pointer=0; retry count=0; timer=0.
- Command rule: at most one m_* pulse is high in any cycle. A pulse is issued only when m_busy==0.
- States:
  - IDLE: if any req bit is set, select the first set bit starting at the pointer, wrapping. Latch its addr/data, assert gnt for it, then go to ADDR_ISSUE. If req==0, stay.
  - ADDR_ISSUE: m_byte={addr,1'b0}, pulse m_start, then ADDR_RISE.
  - ADDR_RISE / DATA_RISE / STOP_RISE: wait for m_busy=1, then go to the matching _FALL state.
  - ADDR_FALL: on m_busy=0, go to STOP_ISSUE if m_nack=1 (record nack); otherwise go to DATA_ISSUE.
  - DATA_ISSUE: m_byte=data, pulse m_write, then DATA_RISE.
  - DATA_FALL: on m_busy=0, record m_nack and go to STOP_ISSUE.
  - STOP_ISSUE: pulse m_stop, then STOP_RISE.
  - STOP_FALL: on m_busy=0:
    - no NACK recorded: pulse done[i], go to RELEASE.
    - NACK recorded and retry<MAX_RETRY: retry++, go to BACKOFF.
    - otherwise: pulse err[i], go to RELEASE.
  - BACKOFF: count BACKOFF_CYCLES, clear the nack flag, then ADDR_ISSUE. gnt stays held.
  - RELEASE: drop gnt, set pointer=(i+1) mod NUM_REQ, clear retry, go to IDLE.
- Timeout:
  - The timer clears on entry to every *_RISE/*_FALL state and increments while in one.
  - If it reaches TIMEOUT_CYCLES, pulse err[i] and go to RELEASE. No STOP is attempted; the master is assumed hung.
- Latency: req rise to m_start is 2 cycles (IDLE, then ADDR_ISSUE). done follows the STOP_FALL cycle by 1.
- The latched addr/data are used for all retries. Changes on req_addr/req_data during a transaction are ignored.
- A requester dropping req mid-transaction does not abort it; done/err still pulse.
- A req bit of a non-granted requester is ignored until RELEASE.
- Simultaneous requests are served strictly round-robin, and the last-served requester has lowest priority.
- Mid-transaction reset returns everything to reset values immediately. The master must be reset with the same rst_n.

Test Plan:
- Single write: req[0]=1, addr=0x27, data=0xA5, master always ACKs. Expect m_start with m_byte=0x4E, then m_write 0xA5, then m_stop. Expect one done[0] pulse and gnt[0] high throughout.
- Contention: req=2'b11 in the same cycle from reset. Expect requester 0 then requester 1. Re-request both after completion: served in order 0 then 1, with pointer wraparound checked at NUM_REQ=3.
- Address NACK: master NACKs the address every time, MAX_RETRY=3. Expect 4 m_start/m_stop pairs, no m_write, BACKOFF gaps ≥1000 cycles, then one err[0] pulse and gnt dropped.
- Data NACK once then ACK. Expect 2 full attempts and a done pulse, no err.
- Timeout: m_busy never rises after m_start. Expect err pulse exactly TIMEOUT_CYCLES after entry to ADDR_RISE, no m_stop, return to IDLE.
- Reset mid-DATA_FALL: all outputs return to 0 asynchronously. Then a new req completes normally.

Source files
------------

// File: rtl/i2c_write_scheduler.sv
// Round-robin scheduler that turns single-byte write requests into START+addr,
// data and STOP commands for a shared byte-level I2C master, with NACK retry and timeouts.
module i2c_write_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int BACKOFF_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 m_start,
  output logic                 m_write,
  output logic                 m_stop,
  output logic [7:0]           m_byte,
  input  logic                 m_busy,
  input  logic                 m_nack,
  output logic                 active
);

  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_ISSUE,
    S_ADDR_RISE,
    S_ADDR_FALL,
    S_DATA_ISSUE,
    S_DATA_RISE,
    S_DATA_FALL,
    S_STOP_ISSUE,
    S_STOP_RISE,
    S_STOP_FALL,
    S_BACKOFF,
    S_RELEASE
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] pick;
  logic          found;
  logic [RW-1:0] retry;
  logic [TW-1:0] timer;
  logic          nack;
  logic [6:0]    cur_addr;
  logic [7:0]    cur_data;
  logic [6:0]    addr_arr [NUM_REQ];
  logic [7:0]    data_arr [NUM_REQ];
  logic          in_wait;
  logic          wait_met;
  logic          timed_out;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*7 +: 7];
      data_arr[i] = req_data[i*8 +: 8];
    end
  end

  // First set request at or after the pointer, wrapping around.
  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    pick  = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        pick  = jj;
      end
    end
  end

  assign in_wait   = (state == S_ADDR_RISE) || (state == S_DATA_RISE) || (state == S_STOP_RISE) ||
                     (state == S_ADDR_FALL) || (state == S_DATA_FALL) || (state == S_STOP_FALL);
  assign wait_met  = ((state == S_ADDR_RISE) || (state == S_DATA_RISE) || (state == S_STOP_RISE))
                     ? m_busy : !m_busy;
  assign timed_out = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign active    = (state != S_IDLE);

  // NOTE: all state below is registered with non-blocking assignments so every
  // branch sees the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      sel      <= '0;
      retry    <= '0;
      timer    <= '0;
      nack     <= 1'b0;
      cur_addr <= '0;
      cur_data <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= '0;
      m_start  <= 1'b0;
      m_write  <= 1'b0;
      m_stop   <= 1'b0;
      m_byte   <= '0;
    end else begin
      m_start <= 1'b0;
      m_write <= 1'b0;
      m_stop  <= 1'b0;
      done    <= '0;
      err     <= '0;

      if (in_wait && !wait_met && timed_out) begin
        // Master assumed hung: abandon without attempting STOP.
        err   <= gnt;
        state <= S_RELEASE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (found) begin
              sel      <= pick;
              gnt      <= GNT_ONE << pick;
              cur_addr <= addr_arr[pick];
              cur_data <= data_arr[pick];
              nack     <= 1'b0;
              state    <= S_ADDR_ISSUE;
            end
          end
          S_ADDR_ISSUE: begin
            if (!m_busy) begin
              m_byte  <= {cur_addr, 1'b0};
              m_start <= 1'b1;
              timer   <= '0;
              state   <= S_ADDR_RISE;
            end
          end
          S_ADDR_RISE, S_DATA_RISE, S_STOP_RISE: begin
            if (m_busy) begin
              timer <= '0;
              state <= (state == S_ADDR_RISE) ? S_ADDR_FALL :
                       (state == S_DATA_RISE) ? S_DATA_FALL : S_STOP_FALL;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_ADDR_FALL: begin
            if (!m_busy) begin
              if (m_nack) begin
                nack  <= 1'b1;
                state <= S_STOP_ISSUE;
              end else begin
                state <= S_DATA_ISSUE;
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_DATA_ISSUE: begin
            if (!m_busy) begin
              m_byte  <= cur_data;
              m_write <= 1'b1;
              timer   <= '0;
              state   <= S_DATA_RISE;
            end
          end
          S_DATA_FALL: begin
            if (!m_busy) begin
              nack  <= m_nack;
              state <= S_STOP_ISSUE;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_STOP_ISSUE: begin
            if (!m_busy) begin
              m_stop <= 1'b1;
              timer  <= '0;
              state  <= S_STOP_RISE;
            end
          end
          S_STOP_FALL: begin
            if (!m_busy) begin
              if (!nack) begin
                done  <= gnt;
                state <= S_RELEASE;
              end else if (retry < RW'(MAX_RETRY)) begin
                retry <= retry + RW'(1);
                timer <= '0;
                state <= S_BACKOFF;
              end else begin
                err   <= gnt;
                state <= S_RELEASE;
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_BACKOFF: begin
            if (timer == TW'(BACKOFF_CYCLES - 1)) begin
              nack  <= 1'b0;
              timer <= '0;
              state <= S_ADDR_ISSUE;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_RELEASE: begin
            gnt   <= '0;
            ptr   <= (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);
            retry <= '0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
